sdram_byte_bridge: RTL and testbench
====================================

Name: sdram_byte_bridge

Overview:
- Upstream stage of the SDRAM controller. Converts 8-bit CPU/bus byte accesses into the controller's 16-bit word handshake (host_* request side).
- Byte writes are done as read-modify-write, because the controller ties its data masks (DM) to 0 and always writes full words.
- Byte reads fetch the whole word and select the addressed lane.
- Adds request hold and anti-retrigger gating, a watchdog timeout, and an optional one-word cache.

Parameters:
- BYTE_ADDR_W, 25: CPU byte address width; word address = cpu_addr[BYTE_ADDR_W-1:1], zero-extended to 24 bits.
- TIMEOUT, 1023: maximum cycles per SDRAM transaction before abort.

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  one-cycle access strobe; sampled only while cpu_busy=0.
- cpu_we  in  1  1=write, 0=read; sampled with cpu_req.
- cpu_addr  in  BYTE_ADDR_W  byte address; bit0 = lane (0 -> [7:0], 1 -> [15:8]).
- cpu_wdata  in  8  write byte.
- cpu_rdata  out  8  read byte; valid while cpu_ack=1, held until next read completes.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  one-cycle pulse with cpu_ack on timeout.
- cpu_busy  out  1  high from the cycle after an accepted request until the cycle after cpu_ack.
- mem_rd_req  out  1  to host_rd_req.
- mem_wr_req  out  1  to host_wr_req.
- mem_addr  out  24  to host_addr (word address).
- mem_wdata  out  16  to host_data_in.
- mem_rdata  in  16  from host_data_out.
- mem_busy  in  1  from host_busy.
- mem_rd_valid  in  1  from host_rd_valid.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cpu_rdata=0, cpu_ack=0, cpu_err=0, cpu_busy=0, mem_addr=0, mem_wdata=0, internal pend/accepted flags=0, timer=0, cache invalid. Reset mid-transaction aborts it with no ack; mem_*_req drop immediately.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - Accept when cpu_req=1 and cpu_busy=0. Latch address, lane, we, wdata; set cpu_busy=1.
  - Always go to RD with rd_pend=1: reads and RMW writes both need the word first.
- Request hold: the controller decides read vs write from req levels during its ACTIVE state, so a pend stays asserted until completion. mem_addr and mem_wdata stay stable for the whole transaction.
- accepted flag: set on the first cycle mem_busy=1 while pending; cleared on entering a new request state.
- Anti-retrigger gating: completion is only visible one edge late, so the request outputs are combinationally gated:
  - mem_rd_req = rd_pend & ~mem_rd_valid.
  - mem_wr_req = wr_pend & ~(accepted & ~mem_busy).
  - The controller must never see the request in IDLE after completion. This is a verification assertion: exactly one controller access per phase.
- RD:
  - On mem_rd_valid, capture mem_rdata and clear rd_pend.
  - Read: cpu_rdata = selected lane, go to DONE.
  - Write: merge cpu_wdata into the selected lane, keep the other lane, drive the result on mem_wdata, set wr_pend=1, clear accepted, go to WR.
- WR: complete when accepted=1 and mem_busy=0; clear wr_pend, go to DONE.
- DONE: cpu_ack=1 for one cycle; cpu_busy=0 next cycle; state -> IDLE.
- Latency (uncached): read = controller read latency + 2 cycles; write = read + write latency + 2 cycles.
- Watchdog:
  - timer resets on entry to RD/WR and counts each cycle.
  - At timer==TIMEOUT: clear pends, cpu_err=1 with cpu_ack, cpu_rdata=8'hFF, no write issued, state -> IDLE.
- cpu_req while busy is ignored (no queueing).
- mem_rd_valid outside RD is ignored.
- Address beyond 24-bit word space: upper bits are truncated.

Optional Feature:
- Macro SDRAM_BRIDGE_CACHE_EN.
- Defined: one-entry word cache (tag = word address, 16-bit data, valid bit).
  - Filled on every completed read phase; updated with merged data on every completed write.
  - Read hit: no SDRAM access; cpu_ack two cycles after cpu_req (IDLE -> DONE).
  - Write hit: skip RD; merge from cache, go straight to WR.
  - Timeout invalidates the cache. The bridge is the sole SDRAM master, so no external invalidation is needed.
- Undefined: no cache logic; every access goes through SDRAM as above.

Test Plan:
- Read lane select: memory word 0x0010 = 16'hBEEF; read cpu_addr 0x20 -> cpu_rdata 8'hEF; read 0x21 -> 8'hBE; one controller read each; cpu_ack single pulse.
- RMW write: word 0x0010 = 16'hBEEF, write 0x21 with 8'h5A -> controller sees read then write of 16'h5AEF to word 0x0010; cpu_err=0.
- Anti-retrigger: fast controller model that completes in 1 cycle -> exactly one host access per phase; mem_rd_req low on the edge after mem_rd_valid.
- Busy/ignore: cpu_req pulsed during an active write -> ignored; one ack only; cpu_busy deasserts the cycle after ack.
- Timeout: controller never raises mem_rd_valid -> after 1023 cycles cpu_ack=cpu_err=1, cpu_rdata=8'hFF, pends cleared, no write issued.
- Reset mid-op, and cache with SDRAM_BRIDGE_CACHE_EN:
  - rst_n low during WR -> all outputs 0 at once.
  - After re-init, two reads of 0x20 -> second returns 8'hEF with no controller request, ack two cycles after cpu_req.

Source files
------------

// File: rtl/sdram_byte_bridge.sv
// sdram_byte_bridge: turns 8-bit CPU byte accesses into 16-bit SDRAM host word transactions
// (byte writes by read-modify-write). Define SDRAM_BRIDGE_CACHE_EN for a one-word cache.
module sdram_byte_bridge #(
  parameter int BYTE_ADDR_W = 25,
  parameter int TIMEOUT     = 1023
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [BYTE_ADDR_W-1:0] cpu_addr,
  input  logic [7:0]             cpu_wdata,
  output logic [7:0]             cpu_rdata,
  output logic                   cpu_ack,
  output logic                   cpu_err,
  output logic                   cpu_busy,
  output logic                   mem_rd_req,
  output logic                   mem_wr_req,
  output logic [23:0]            mem_addr,
  output logic [15:0]            mem_wdata,
  input  logic [15:0]            mem_rdata,
  input  logic                   mem_busy,
  input  logic                   mem_rd_valid
);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t        state, state_nx;
  logic          rd_pend, rd_pend_nx, wr_pend, wr_pend_nx, accepted, accepted_nx;
  logic          lane, lane_nx, we, we_nx;
  logic [7:0]    wbyte, wbyte_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [7:0]    rdata_nx;
  logic          ack_nx, err_nx, busy_nx, abort;
  logic [23:0]   addr_nx, word_addr;
  logic [15:0]   wdata_nx;

  function automatic logic [15:0] merge_lane(input logic [15:0] word, input logic hi,
                                             input logic [7:0] b);
    return hi ? {b, word[7:0]} : {word[15:8], b};
  endfunction

  function automatic logic [7:0] pick_lane(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

  assign word_addr = 24'(cpu_addr[BYTE_ADDR_W-1:1]);

  // Completion is only seen one edge late, so mask the request in the completing cycle.
  assign mem_rd_req = rd_pend & ~mem_rd_valid;
  assign mem_wr_req = wr_pend & ~(accepted & ~mem_busy);

`ifdef SDRAM_BRIDGE_CACHE_EN
  logic        c_valid, c_valid_nx, c_hit;
  logic [23:0] c_tag, c_tag_nx;
  logic [15:0] c_data, c_data_nx;
  assign c_hit = c_valid && (c_tag == word_addr);
`endif

  always_comb begin
    state_nx    = state;
    rd_pend_nx  = rd_pend;
    wr_pend_nx  = wr_pend;
    accepted_nx = accepted | ((rd_pend | wr_pend) & mem_busy);
    lane_nx     = lane;
    we_nx       = we;
    wbyte_nx    = wbyte;
    timer_nx    = timer;
    rdata_nx    = cpu_rdata;
    ack_nx      = 1'b0;
    err_nx      = 1'b0;
    busy_nx     = cpu_busy;
    addr_nx     = mem_addr;
    wdata_nx    = mem_wdata;
    abort       = 1'b0;
`ifdef SDRAM_BRIDGE_CACHE_EN
    c_valid_nx  = c_valid;
    c_tag_nx    = c_tag;
    c_data_nx   = c_data;
`endif
    case (state)
      IDLE: begin
        if (cpu_ack) begin
          busy_nx = 1'b0;
        end else if (cpu_req && !cpu_busy) begin
          lane_nx     = cpu_addr[0];
          we_nx       = cpu_we;
          wbyte_nx    = cpu_wdata;
          addr_nx     = word_addr;
          busy_nx     = 1'b1;
          timer_nx    = '0;
          accepted_nx = 1'b0;
          rd_pend_nx  = 1'b1;
          state_nx    = RD;
`ifdef SDRAM_BRIDGE_CACHE_EN
          if (c_hit && !cpu_we) begin
            rd_pend_nx = 1'b0;
            rdata_nx   = pick_lane(c_data, cpu_addr[0]);
            state_nx   = DONE;
          end else if (c_hit) begin
            rd_pend_nx = 1'b0;
            wdata_nx   = merge_lane(c_data, cpu_addr[0], cpu_wdata);
            wr_pend_nx = 1'b1;
            state_nx   = WR;
          end
`endif
        end
      end
      RD: begin
        timer_nx = timer + TW'(1);
        if (mem_rd_valid) begin
          rd_pend_nx = 1'b0;
`ifdef SDRAM_BRIDGE_CACHE_EN
          c_valid_nx = 1'b1;
          c_tag_nx   = mem_addr;
          c_data_nx  = mem_rdata;
`endif
          if (we) begin
            wdata_nx    = merge_lane(mem_rdata, lane, wbyte);
            wr_pend_nx  = 1'b1;
            accepted_nx = 1'b0;
            timer_nx    = '0;
            state_nx    = WR;
          end else begin
            rdata_nx = pick_lane(mem_rdata, lane);
            state_nx = DONE;
          end
        end else if (timer == TW'(TIMEOUT)) begin
          abort = 1'b1;
        end
      end
      WR: begin
        timer_nx = timer + TW'(1);
        if (accepted && !mem_busy) begin
          wr_pend_nx = 1'b0;
          state_nx   = DONE;
`ifdef SDRAM_BRIDGE_CACHE_EN
          c_valid_nx = 1'b1;
          c_tag_nx   = mem_addr;
          c_data_nx  = mem_wdata;
`endif
        end else if (timer == TW'(TIMEOUT)) begin
          abort = 1'b1;
        end
      end
      DONE: begin
        ack_nx   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      rd_pend_nx = 1'b0;
      wr_pend_nx = 1'b0;
      ack_nx     = 1'b1;
      err_nx     = 1'b1;
      rdata_nx   = 8'hFF;
      state_nx   = IDLE;
`ifdef SDRAM_BRIDGE_CACHE_EN
      c_valid_nx = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_pend   <= 1'b0;
      wr_pend   <= 1'b0;
      accepted  <= 1'b0;
      lane      <= 1'b0;
      we        <= 1'b0;
      wbyte     <= '0;
      timer     <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_busy  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nx;
      rd_pend   <= rd_pend_nx;
      wr_pend   <= wr_pend_nx;
      accepted  <= accepted_nx;
      lane      <= lane_nx;
      we        <= we_nx;
      wbyte     <= wbyte_nx;
      timer     <= timer_nx;
      cpu_rdata <= rdata_nx;
      cpu_ack   <= ack_nx;
      cpu_err   <= err_nx;
      cpu_busy  <= busy_nx;
      mem_addr  <= addr_nx;
      mem_wdata <= wdata_nx;
    end
  end

`ifdef SDRAM_BRIDGE_CACHE_EN
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      c_valid <= 1'b0;
      c_tag   <= '0;
      c_data  <= '0;
    end else begin
      c_valid <= c_valid_nx;
      c_tag   <= c_tag_nx;
      c_data  <= c_data_nx;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_byte_bridge.sv
// Bench for sdram_byte_bridge: transaction-level bridge model, a cycle-level SDRAM host model,
// and directed accesses. Build with SDRAM_BRIDGE_CACHE_EN defined to cover the cached variant.
`timescale 1ns/1ps
module tb_sdram_byte_bridge;
  localparam int BYTE_ADDR_W = 25;
  localparam int TIMEOUT     = 1023;
`ifdef SDRAM_BRIDGE_CACHE_EN
  localparam bit CACHED = 1'b1;
`else
  localparam bit CACHED = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [24:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack, cpu_err, cpu_busy;
  logic        mem_rd_req, mem_wr_req;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_busy = 1'b0, mem_rd_valid = 1'b0;

  sdram_byte_bridge #(.BYTE_ADDR_W(BYTE_ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
    .mem_rd_valid(mem_rd_valid)
  );

  initial forever #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  initial forever begin
    @(posedge clk_sys);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SDRAM host model: samples requests mid-cycle, reacts on the next edge.
  logic [15:0] ctl_mem [256];
  int          n_rd = 0, n_wr = 0, done_cyc = 0, lat = 3;
  bit          hang = 1'b0;
  logic [23:0] last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;
  logic        s_rq = 1'b0, s_wq = 1'b0;
  logic [23:0] s_addr = '0;
  logic [15:0] s_wdata = '0;

  initial forever begin
    @(negedge clk_sys);
    s_rq = mem_rd_req; s_wq = mem_wr_req; s_addr = mem_addr; s_wdata = mem_wdata;
  end

  initial begin : host_model
    bit          active;
    bit          c_wr;
    int          cnt;
    logic [23:0] c_addr;
    logic [15:0] c_data;
    active = 1'b0; c_wr = 1'b0; cnt = 0; c_addr = '0; c_data = '0;
    forever begin
      @(posedge clk_sys); #1;
      mem_rd_valid = 1'b0;
      if (!rst_n) begin
        active = 1'b0;
        mem_busy = 1'b0;
      end else if (!active) begin
        if (!hang && (s_rq || s_wq)) begin
          c_wr = s_wq && !s_rq; c_addr = s_addr; c_data = s_wdata;
          if (c_wr) n_wr++; else n_rd++;
          active = 1'b1; cnt = lat; mem_busy = 1'b1;
        end
      end else if (cnt > 1) begin
        cnt--;
      end else begin
        active = 1'b0; mem_busy = 1'b0; done_cyc = cyc;
        if (c_wr) begin
          ctl_mem[c_addr[7:0]] = c_data; last_wr_addr = c_addr; last_wr_data = c_data;
        end else begin
          mem_rdata = ctl_mem[c_addr[7:0]]; mem_rd_valid = 1'b1;
        end
      end
    end
  end

  // Bridge model: expected completion of each accepted CPU access.
  typedef struct {
    logic       we;
    logic       err;
    logic [7:0] rdata;
    int         req_cyc;
    bit         from_req;
    int         lat;
  } exp_t;
  exp_t        expq[$];
  logic [15:0] model_mem [256];
  bit          mc_valid = 1'b0;
  logic [23:0] mc_tag = '0;
  int          last_ack_cyc = -10;

  initial begin : compare
    logic  prev_rv;
    exp_t  e;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!rst_n) begin
        prev_rv = 1'b0;
        continue;
      end
      if (mem_rd_valid) check("rd_req_gated_on_valid", 32'(mem_rd_req), 0);
      if (prev_rv) check("rd_req_low_after_valid", 32'(mem_rd_req), 0);
      if (cpu_err) check("err_with_ack", 32'(cpu_ack), 1);
      if (cyc == last_ack_cyc + 1) begin
        check("ack_single_pulse", 32'(cpu_ack), 0);
        check("busy_low_after_ack", 32'(cpu_busy), 0);
      end
      if (cpu_ack) begin
        check("ack_expected", 32'(expq.size() != 0), 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          check("ack_err", 32'(cpu_err), 32'(e.err));
          if (!e.we || e.err) check("rdata", 32'(cpu_rdata), 32'(e.rdata));
          check("busy_during_ack", 32'(cpu_busy), 1);
          if (e.from_req) check("ack_latency_from_req", cyc - e.req_cyc, e.lat);
          else            check("ack_latency_from_host_done", cyc - done_cyc, e.lat);
        end
        last_ack_cyc = cyc;
      end
      prev_rv = mem_rd_valid;
    end
  end

  task automatic access(input logic w, input logic [24:0] a, input logic [7:0] b,
                        input int stray);
    exp_t        e;
    logic [23:0] wa;
    logic [15:0] old, nw;
    int          rd0, wr0, t;
    bit          hit;
    wa  = a[24:1];
    old = model_mem[wa[7:0]];
    hit = CACHED && mc_valid && (mc_tag == wa);
    nw  = a[0] ? {b, old[7:0]} : {old[15:8], b};
    e.we = w;
    e.err = hang;
    e.rdata = hang ? 8'hFF : (a[0] ? old[15:8] : old[7:0]);
    e.from_req = hang || (hit && !w);
    e.lat = hang ? TIMEOUT + 2 : 2;
    @(posedge clk_sys); #1;
    rd0 = n_rd; wr0 = n_wr;
    cpu_req = 1'b1; cpu_we = w; cpu_addr = a; cpu_wdata = b;
    e.req_cyc = cyc;
    expq.push_back(e);
    @(posedge clk_sys); #1;
    cpu_req = 1'b0; cpu_we = ~w; cpu_wdata = ~b;
    check("busy_after_req", 32'(cpu_busy), 1);
    t = 0;
    do begin
      @(negedge clk_sys);
      t++;
      cpu_req = (t == stray);
      if (t == stray) begin
        cpu_we = 1'b1; cpu_addr = 25'h81;
      end
    end while (!cpu_ack && t < 3000);
    if (!cpu_ack) check("ack_within_budget", 32'(cpu_ack), 1);
    cpu_req = 1'b0;
    @(negedge clk_sys);
    check("host_reads", n_rd - rd0, (hang || hit) ? 0 : 1);
    check("host_writes", n_wr - wr0, (w && !hang) ? 1 : 0);
    if (hang) begin
      check("rd_pend_cleared", 32'(mem_rd_req), 0);
      check("wr_pend_cleared", 32'(mem_wr_req), 0);
      mc_valid = 1'b0;
    end else begin
      if (w) begin
        check("write_word_addr", 32'(last_wr_addr), 32'(wa));
        check("write_word_data", 32'(last_wr_data), 32'(nw));
        model_mem[wa[7:0]] = nw;
      end
      mc_valid = 1'b1;
      mc_tag = wa;
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    errors++;
    $display("FAIL global_time_limit actual=expired required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : stimulus
    int t;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 16'(i * 291 + 17767);
      ctl_mem[i]   = 16'(i * 291 + 17767);
    end
    model_mem[8'h10] = 16'hBEEF;
    ctl_mem[8'h10]   = 16'hBEEF;

    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_cpu_rdata", 32'(cpu_rdata), 0);
    check("rst_cpu_ack", 32'(cpu_ack), 0);
    check("rst_cpu_err", 32'(cpu_err), 0);
    check("rst_cpu_busy", 32'(cpu_busy), 0);
    check("rst_mem_rd_req", 32'(mem_rd_req), 0);
    check("rst_mem_wr_req", 32'(mem_wr_req), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    @(negedge clk_sys) rst_n = 1'b1;

    lat = 3;
    access(1'b0, 25'h20, 8'h00, 0);
    check("pin_read_0x20", 32'(cpu_rdata), 32'h00EF);
    access(1'b0, 25'h21, 8'h00, 0);
    check("pin_read_0x21", 32'(cpu_rdata), 32'h00BE);

    lat = 1;
    access(1'b1, 25'h21, 8'h5A, 0);
    check("pin_rmw_word", 32'(last_wr_data), 32'h5AEF);
    check("pin_rmw_addr", 32'(last_wr_addr), 32'h0010);
    access(1'b0, 25'h20, 8'h00, 0);
    access(1'b1, 25'h100, 8'h33, 0);
    access(1'b0, 25'h100, 8'h00, 0);
    check("pin_read_0x100", 32'(cpu_rdata), 32'h0033);
    access(1'b0, 25'h101, 8'h00, 0);

    lat = 5;
    access(1'b1, 25'h41, 8'hC3, 4);

    hang = 1'b1;
    access(1'b1, 25'h50, 8'h77, 0);
    check("pin_timeout_rdata", 32'(cpu_rdata), 32'h00FF);
    hang = 1'b0;

    lat = 2;
    access(1'b1, 25'h21, 8'hBE, 0);

    lat = 6;
    @(posedge clk_sys); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h61; cpu_wdata = 8'h11;
    @(posedge clk_sys); #1;
    cpu_req = 1'b0;
    t = 0;
    while (!mem_wr_req && t < 200) begin
      @(negedge clk_sys);
      t++;
    end
    check("reached_write_phase", 32'(mem_wr_req), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midop_cpu_rdata", 32'(cpu_rdata), 0);
    check("midop_cpu_ack", 32'(cpu_ack), 0);
    check("midop_cpu_err", 32'(cpu_err), 0);
    check("midop_cpu_busy", 32'(cpu_busy), 0);
    check("midop_mem_rd_req", 32'(mem_rd_req), 0);
    check("midop_mem_wr_req", 32'(mem_wr_req), 0);
    check("midop_mem_addr", 32'(mem_addr), 0);
    check("midop_mem_wdata", 32'(mem_wdata), 0);
    repeat (3) @(posedge clk_sys);
    mc_valid = 1'b0;
    expq.delete();
    @(negedge clk_sys) rst_n = 1'b1;

    lat = 3;
    access(1'b0, 25'h20, 8'h00, 0);
    access(1'b0, 25'h20, 8'h00, 0);
    check("pin_reread_0x20", 32'(cpu_rdata), 32'h00EF);
    access(1'b1, 25'h20, 8'h99, 0);
    access(1'b0, 25'h20, 8'h00, 0);
    check("pin_read_after_write", 32'(cpu_rdata), 32'h0099);

    repeat (4) @(posedge clk_sys);
    check("queue_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
